// File: rtl/reset_seq_pkg.sv
// Shared state encoding and elaboration helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold max_cycles-1; a counter is never narrower than 1 bit.
  function automatic int min_cnt_w(input int max_cycles);
    return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Lock-qualified reset sequencer: wait, common pulse, then staggered per-output release.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int N_OUT          = 4,
  parameter int WAIT_CYCLES    = 20,
  parameter int PULSE_CYCLES   = 32,
  parameter int STAGGER_CYCLES = 8,
  parameter int CNT_W          = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dcm_locked,
  input  logic             soft_rst_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             all_released,
  output logic             seq_busy
);

  localparam int MAX_LEN = max3(WAIT_CYCLES, PULSE_CYCLES, STAGGER_CYCLES);
  localparam int IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  generate
    if (CNT_W < min_cnt_w(MAX_LEN)) begin : g_cnt_w_chk
      $error("reset_seq: CNT_W=%0d cannot hold %0d", CNT_W, MAX_LEN - 1);
    end
  endgenerate

  logic             locked_s;
  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [N_OUT-1:0] rst_nxt;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dcm_locked),
    .q     (locked_s)
  );

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    idx_nxt = idx;
    rst_nxt = rst_out;
    case (st)
      S_IDLE: begin
        rst_nxt = '1;
        cnt_nxt = '0;
        if (locked_s) st_nxt = S_WAIT;
      end
      S_WAIT: begin
        rst_nxt = '1;
        if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
          st_nxt  = S_ASSERT;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_ASSERT: begin
        rst_nxt = '1;
        if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
          cnt_nxt    = '0;
          idx_nxt    = '0;
          rst_nxt[0] = 1'b0;
          st_nxt     = (N_OUT == 1) ? S_RUN : S_RELEASE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
          cnt_nxt = '0;
          idx_nxt = idx + IDX_W'(1);
          for (int i = 1; i < N_OUT; i++)
            if (i == int'(idx) + 1) rst_nxt[i] = 1'b0;
          if (int'(idx) + 1 == N_OUT - 1) st_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        rst_nxt = '0;
        cnt_nxt = '0;
        if (soft_rst_req) begin
          st_nxt  = S_ASSERT;
          rst_nxt = '1;
        end
      end
      default: begin
        st_nxt  = S_IDLE;
        cnt_nxt = '0;
        rst_nxt = '1;
      end
    endcase
    // Losing lock outranks everything, including already-released outputs.
    if (!locked_s && st != S_IDLE) begin
      st_nxt  = S_IDLE;
      cnt_nxt = '0;
      idx_nxt = '0;
      rst_nxt = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      rst_out      <= '1;
      all_released <= 1'b0;
      seq_busy     <= 1'b1;
    end else begin
      st           <= st_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      rst_out      <= rst_nxt;
      all_released <= ~|rst_nxt;
      seq_busy     <= (st_nxt != S_RUN);
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle; monitors compare each change.
module tb_reset_seq;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       all_rel;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dcm_locked = 1'b1;
  logic       dcm_locked1 = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [3:0] rst_out0;
  logic       all_rel0, busy0;
  logic [0:0] rst_out1;
  logic       all_rel1, busy1;

  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;
  exp_t q0[$];
  exp_t q1[$];

  reset_seq u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .dcm_locked   (dcm_locked),
    .soft_rst_req (soft_rst_req),
    .rst_out      (rst_out0),
    .all_released (all_rel0),
    .seq_busy     (busy0)
  );

  reset_seq #(
    .N_OUT(1), .WAIT_CYCLES(1), .PULSE_CYCLES(1), .STAGGER_CYCLES(1)
  ) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .dcm_locked   (dcm_locked1),
    .soft_rst_req (1'b0),
    .rst_out      (rst_out1),
    .all_released (all_rel1),
    .seq_busy     (busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: every change of the output bundle must match the head of the queue.
  logic [5:0] prev0;
  always @(negedge clk) begin : mon0
    logic [5:0] cur;
    exp_t e;
    cur = {rst_out0, all_rel0, busy0};
    if (!rst_n) prev0 = cur;
    else if (cur !== prev0) begin
      prev0 = cur;
      ntests++;
      if (q0.size() == 0) begin
        nfail++;
        $display("FAIL dut0_unexpected: got %b at cycle %0d, expected no change", cur, cyc);
      end else begin
        e = q0.pop_front();
        if (e.cyc != cyc || cur !== {e.rst, e.all_rel, e.busy}) begin
          nfail++;
          $display("FAIL dut0_change: got %b at cycle %0d, expected %b at cycle %0d",
                   cur, cyc, {e.rst, e.all_rel, e.busy}, e.cyc);
        end
      end
    end
  end

  logic [2:0] prev1;
  always @(negedge clk) begin : mon1
    logic [2:0] cur;
    exp_t e;
    cur = {rst_out1, all_rel1, busy1};
    if (!rst_n) prev1 = cur;
    else if (cur !== prev1) begin
      prev1 = cur;
      ntests++;
      if (q1.size() == 0) begin
        nfail++;
        $display("FAIL dut1_unexpected: got %b at cycle %0d, expected no change", cur, cyc);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || cur !== {e.rst[0], e.all_rel, e.busy}) begin
          nfail++;
          $display("FAIL dut1_change: got %b at cycle %0d, expected %b at cycle %0d",
                   cur, cyc, {e.rst[0], e.all_rel, e.busy}, e.cyc);
        end
      end
    end
  end

  task automatic push0(input int c, input logic [3:0] r, input logic a, input logic b);
    exp_t e;
    e.cyc = c; e.rst = r; e.all_rel = a; e.busy = b;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic r, input logic a, input logic b);
    exp_t e;
    e.cyc = c; e.rst = {3'b000, r}; e.all_rel = a; e.busy = b;
    q1.push_back(e);
  endtask

  // Releases of a sequence whose first WAIT cycle starts at edge t0 (20 wait + 32 pulse, stagger 8).
  task automatic push_seq(input int t0, input int nbits);
    if (nbits > 0) push0(t0 + 52, 4'b1110, 1'b0, 1'b1);
    if (nbits > 1) push0(t0 + 60, 4'b1100, 1'b0, 1'b1);
    if (nbits > 2) push0(t0 + 68, 4'b1000, 1'b0, 1'b1);
    if (nbits > 3) push0(t0 + 76, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_soft();
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
  endtask

  initial begin
    int t0, x;
    repeat (5) @(negedge clk);
    chk("reset_rst_out0", 32'(rst_out0), 32'hF);
    chk("reset_all_rel0", 32'(all_rel0), 32'h0);
    chk("reset_busy0",    32'(busy0),    32'h1);
    chk("reset_rst_out1", 32'(rst_out1), 32'h1);
    chk("reset_all_rel1", 32'(all_rel1), 32'h0);
    chk("reset_busy1",    32'(busy1),    32'h1);

    // Power-up with lock already stable; requests during WAIT/ASSERT must be ignored.
    x = cyc; rst_n = 1'b1; t0 = x + 3;
    push_seq(t0, 4);
    wait_until(t0 + 5);  pulse_soft();
    wait_until(t0 + 30); pulse_soft();

    // Soft reset from RUN: no WAIT, pulse of 32 then staggered release.
    wait_until(t0 + 80);
    x = cyc;
    push0(x + 1,  4'b1111, 1'b0, 1'b1);
    push0(x + 33, 4'b1110, 1'b0, 1'b1);
    push0(x + 41, 4'b1100, 1'b0, 1'b1);
    push0(x + 49, 4'b1000, 1'b0, 1'b1);
    push0(x + 57, 4'b0000, 1'b1, 1'b0);
    pulse_soft();

    // Soft request and lock drop together in RUN, then relock.
    wait_until(x + 60);
    x = cyc;
    push0(x + 1, 4'b1111, 1'b0, 1'b1);
    dcm_locked = 1'b0;
    pulse_soft();
    wait_until(x + 12);
    x = cyc; dcm_locked = 1'b1; t0 = x + 3;
    push_seq(t0, 2);

    // Lock drop mid-RELEASE with bits 0 and 1 already released.
    wait_until(t0 + 62);
    dcm_locked = 1'b0;
    push0(t0 + 65, 4'b1111, 1'b0, 1'b1);
    wait_until(t0 + 72);
    x = cyc; dcm_locked = 1'b1; t0 = x + 3;
    push_seq(t0, 4);
    wait_until(t0 + 80);

    // Minimal configuration on the second instance.
    x = cyc; dcm_locked1 = 1'b1;
    push1(x + 5, 1'b0, 1'b1, 1'b0);
    wait_until(x + 10);

    chk("final_rst_out0", 32'(rst_out0), 32'h0);
    chk("final_busy0",    32'(busy0),    32'h0);
    chk("final_rst_out1", 32'(rst_out1), 32'h0);
    chk("final_all_rel1", 32'(all_rel1), 32'h1);
    chk("pending_dut0",   32'(q0.size()), 32'h0);
    chk("pending_dut1",   32'(q1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
